// File: rtl/mul_div_unit.sv
// mul_div_unit
//
// Multiply/divide unit for the MIPS execute stage. It takes the forwarded
// rs/rt operands and maintains the architectural HI/LO pair. Long operations
// (MULT, MULTU, DIV, DIVU and, when enabled, MADD/MSUB) compute their full
// 64-bit result at the accept edge. That result is held privately while a
// busy counter runs. It is committed to HI/LO only when the counter expires,
// so HI/LO never show a partial result.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU/MADD/MSUB (1..255)
//   DIV_CYCLES   busy cycles for DIV/DIVU (1..255)
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high; discards any in-flight result
//   start  in   qualifies op for one cycle; ignored while busy
//   op     in   [3:0] 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//               7 MADD, 8 MSUB, 9..15 NOP
//   A      in   [31:0] rs operand
//   B      in   [31:0] rt operand
//   busy   out  long operation in flight
//   HI     out  [31:0] committed HI
//   LO     out  [31:0] committed LO
//
// Handshake: a command is taken on a rising edge where start=1 and busy=0.
// While busy=1, start is ignored with no side effects. Upstream holds the
// command, or re-issues it, until it sees busy=0.
//
// Build option: define MDU_MADD_EN to enable MADD/MSUB (ops 7/8), which
// accumulate into HI:LO. Without it, ops 7/8 are NOPs.

module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
`endif

  localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
  localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  // Cleared for a divide by zero: the busy sequence still runs, but the
  // commit leaves HI/LO untouched.
  logic        wr_q, wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // ---------------------------------------------------------------------
  // Datapath: products and quotient/remainder for the current operands.
  // ---------------------------------------------------------------------
  logic [63:0] a_sx, b_sx;
  logic [63:0] prod_s, prod_u;

  assign a_sx   = {{32{A[31]}}, A};
  assign b_sx   = {{32{B[31]}}, B};
  // The low 64 bits of the product of sign-extended operands are the exact
  // signed 32x32 product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};

  // One unsigned divider serves both DIV and DIVU. A signed divide runs on
  // magnitudes, and the signs are applied afterwards. This also makes
  // 0x8000_0000 / -1 come out as 0x8000_0000 rem 0 without overflow.
  logic        div_signed;
  logic [31:0] a_mag, b_mag;
  logic [31:0] dvd, dvs;
  logic [31:0] uq, ur;
  logic [31:0] quo, rem;

  always_comb begin
    div_signed = (op == OP_DIV);
    a_mag      = A[31] ? (32'd0 - A) : A;
    b_mag      = B[31] ? (32'd0 - B) : B;
    dvd        = div_signed ? a_mag : A;
    dvs        = div_signed ? b_mag : B;
    // A zero divisor is replaced by one so the divider never sees zero.
    // The result is discarded anyway.
    if (dvs == 32'd0) begin
      dvs = 32'd1;
    end
    uq  = dvd / dvs;
    ur  = dvd % dvs;
    quo = (div_signed && (A[31] ^ B[31])) ? (32'd0 - uq) : uq;
    rem = (div_signed && A[31]) ? (32'd0 - ur) : ur;
  end

`ifdef MDU_MADD_EN
  logic [63:0] acc_add, acc_sub;
  assign acc_add = {hi_q, lo_q} + prod_s;
  assign acc_sub = {hi_q, lo_q} - prod_s;
`endif

  // ---------------------------------------------------------------------
  // FSM: next state and register updates.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT: begin
              res_d   = prod_s;
              wr_d    = 1'b1;
              cnt_d   = MULT_N;
              state_d = RUN;
            end
            OP_MULTU: begin
              res_d   = prod_u;
              wr_d    = 1'b1;
              cnt_d   = MULT_N;
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              res_d   = {rem, quo};
              wr_d    = (B != 32'd0);
              cnt_d   = DIV_N;
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
            OP_MADD: begin
              res_d   = acc_add;
              wr_d    = 1'b1;
              cnt_d   = MULT_N;
              state_d = RUN;
            end
            OP_MSUB: begin
              res_d   = acc_sub;
              wr_d    = 1'b1;
              cnt_d   = MULT_N;
              state_d = RUN;
            end
`endif
            default: ;
          endcase
        end
      end
      RUN: begin
        // A count of 1 means this edge completes the operation. The "<="
        // test also keeps the FSM from hanging if the counter is ever 0.
        if (cnt_q <= 8'd1) begin
          if (wr_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      res_q   <= 64'd0;
      wr_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit. Inputs are driven on the falling edge, and
// outputs are sampled on the falling edge. The reference model holds the
// architectural HI:LO as one 64-bit value. It computes results with plain
// 64-bit arithmetic.

module tb_mul_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_hilo;
  logic [63:0] exp_q[$];

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .HI(HI), .LO(LO)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  task automatic model_op(input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] nhl,
                          output int cyc);
    longint ps, sa, sb, q, r;
    logic [63:0] pu;
    ps  = longint'($signed(a)) * longint'($signed(b));
    pu  = {32'd0, a} * {32'd0, b};
    nhl = m_hilo;
    cyc = 0;
    case (o)
      4'd1: begin nhl = ps; cyc = MC; end
      4'd2: begin nhl = pu; cyc = MC; end
      4'd3: begin
        cyc = DC;
        if (b != 0) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          nhl = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        cyc = DC;
        if (b != 0) nhl = {a % b, a / b};
      end
      4'd5: nhl = {a, m_hilo[31:0]};
      4'd6: nhl = {m_hilo[63:32], a};
`ifdef MDU_MADD_EN
      4'd7: begin nhl = m_hilo + ps; cyc = MC; end
      4'd8: begin nhl = m_hilo - ps; cyc = MC; end
`endif
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Present a command at a falling edge and let the next rising edge accept
  // it. Then count falling edges while busy is high, up to a bound.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, output int cyc);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // Model update plus drive. The expected HI:LO goes to the scoreboard queue.
  task automatic drive_op(input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int cyc, output int ecyc);
    logic [63:0] nhl;
    model_op(o, a, b, nhl, ecyc);
    exp_q.push_back(nhl);
    m_hilo = nhl;
    do_op(o, a, b, cyc);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 4'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_hilo = 64'd0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
  endtask

  task automatic test_mult();
    int cyc, ecyc;
    logic [63:0] e;
    drive_op(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, cyc, ecyc);
    e = exp_q.pop_front();
    checks++; if (cyc != 5) begin errors++; $display("FAIL mult_cycles: got %0d want 5", cyc); end
    checks++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mult_hilo: got %h want FFFFFFFFFFFFFFFE", {HI, LO}); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL mult_model: got %h want %h", {HI, LO}, e); end
    drive_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, cyc, ecyc);
    e = exp_q.pop_front();
    checks++; if (cyc != 5) begin errors++; $display("FAIL multu_cycles: got %0d want 5", cyc); end
    checks++; if ({HI, LO} !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL multu_hilo: got %h want 00000001FFFFFFFE", {HI, LO}); end
  endtask

  task automatic test_div();
    int cyc, ecyc;
    logic [63:0] e;
    drive_op(4'd3, 32'hFFFF_FFF9, 32'd2, cyc, ecyc);
    e = exp_q.pop_front();
    checks++; if (cyc != 10) begin errors++; $display("FAIL div_cycles: got %0d want 10", cyc); end
    checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h want FFFFFFFD", LO); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h want FFFFFFFF", HI); end
    drive_op(4'd4, 32'd7, 32'd2, cyc, ecyc);
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== 64'h0000_0001_0000_0003) begin errors++; $display("FAIL divu_hilo: got %h want 0000000100000003", {HI, LO}); end
    drive_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc, ecyc);
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_ovf_hilo: got %h want 0000000080000000", {HI, LO}); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL div_ovf_model: got %h want %h", {HI, LO}, e); end
  endtask

  task automatic test_div_by_zero();
    int cyc, ecyc;
    logic [63:0] e;
    logic [31:0] lo_prev;
    drive_op(4'd5, 32'h1234_5678, 32'd0, cyc, ecyc);
    e = exp_q.pop_front();
    checks++; if (cyc != 0) begin errors++; $display("FAIL mthi_busy: got %0d busy cycles want 0", cyc); end
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h want 12345678", HI); end
    lo_prev = m_hilo[31:0];
    drive_op(4'd4, 32'd99, 32'd0, cyc, ecyc);
    e = exp_q.pop_front();
    checks++; if (cyc != 10) begin errors++; $display("FAIL div0_cycles: got %0d want 10", cyc); end
    checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL div0_hi: got %h want 12345678", HI); end
    checks++; if (LO !== lo_prev) begin errors++; $display("FAIL div0_lo: got %h want %h", LO, lo_prev); end
  endtask

  task automatic test_ignore_start();
    int cyc, ecyc;
    logic [63:0] e;
    model_op(4'd3, 32'd100, 32'd7, e, ecyc);
    m_hilo = e;
    start = 1'b1; op = 4'd3; A = 32'd100; B = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 300) begin
      cyc++;
      if (cyc == 3) begin
        start = 1'b1; op = 4'd6; A = 32'hDEAD_BEEF; B = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (cyc != 10) begin errors++; $display("FAIL ignore_cycles: got %0d want 10", cyc); end
    checks++; if (LO !== 32'd14) begin errors++; $display("FAIL ignore_lo: got %h want 0000000e", LO); end
    checks++; if (HI !== 32'd2) begin errors++; $display("FAIL ignore_hi: got %h want 00000002", HI); end
    checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL ignore_model: got %h want %h", {HI, LO}, e); end
  endtask

  task automatic test_reset_midflight();
    start = 1'b1; op = 4'd3; A = 32'd1000; B = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hilo = 64'd0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    checks++; if ({HI, LO} !== 64'd0) begin errors++; $display("FAIL midreset_hilo: got %h want 0", {HI, LO}); end
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b0 || {HI, LO} !== 64'd0) begin
      errors++; $display("FAIL midreset_late_commit: got busy=%b hilo=%h want busy=0 hilo=0", busy, {HI, LO});
    end
  endtask

  task automatic test_back_to_back();
    int cyc1, idle, cyc2, ecyc;
    logic [63:0] e1, e2;
    model_op(4'd1, 32'h0001_2345, 32'hFFFF_0003, e1, ecyc);
    m_hilo = e1;
    model_op(4'd2, 32'h89AB_CDEF, 32'h7654_3210, e2, ecyc);
    m_hilo = e2;
    start = 1'b1; op = 4'd1; A = 32'h0001_2345; B = 32'hFFFF_0003;
    @(posedge clk);
    @(negedge clk);
    op = 4'd2; A = 32'h89AB_CDEF; B = 32'h7654_3210;
    cyc1 = 0;
    while (busy === 1'b1 && cyc1 < 300) begin cyc1++; @(negedge clk); end
    checks++; if (cyc1 != 5) begin errors++; $display("FAIL b2b_first_cycles: got %0d want 5", cyc1); end
    checks++; if ({HI, LO} !== e1) begin errors++; $display("FAIL b2b_first_hilo: got %h want %h", {HI, LO}, e1); end
    idle = 0;
    while (busy !== 1'b1 && idle < 300) begin idle++; @(negedge clk); end
    start = 1'b0;
    checks++; if (idle != 1) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles want 1", idle); end
    checks++; if ({HI, LO} !== e1) begin errors++; $display("FAIL b2b_hold_hilo: got %h want %h", {HI, LO}, e1); end
    cyc2 = 0;
    while (busy === 1'b1 && cyc2 < 300) begin cyc2++; @(negedge clk); end
    checks++; if (cyc2 != 5) begin errors++; $display("FAIL b2b_second_cycles: got %0d want 5", cyc2); end
    checks++; if ({HI, LO} !== e2) begin errors++; $display("FAIL b2b_second_hilo: got %h want %h", {HI, LO}, e2); end
  endtask

  task automatic test_madd();
    int cyc, ecyc;
    logic [63:0] e;
    drive_op(4'd6, 32'd5, 32'd0, cyc, ecyc);
    e = exp_q.pop_front();
    drive_op(4'd5, 32'd0, 32'd0, cyc, ecyc);
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== 64'd5) begin errors++; $display("FAIL madd_setup: got %h want 5", {HI, LO}); end
    drive_op(4'd7, 32'd3, 32'd4, cyc, ecyc);
    e = exp_q.pop_front();
`ifdef MDU_MADD_EN
    checks++; if (cyc != 5) begin errors++; $display("FAIL madd_cycles: got %0d want 5", cyc); end
    checks++; if ({HI, LO} !== 64'h11) begin errors++; $display("FAIL madd_hilo: got %h want 11", {HI, LO}); end
    drive_op(4'd8, 32'h12, 32'd1, cyc, ecyc);
    e = exp_q.pop_front();
    checks++; if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL msub_hilo: got %h want FFFFFFFFFFFFFFFF", {HI, LO}); end
`else
    checks++; if (cyc != 0) begin errors++; $display("FAIL madd_off_busy: got %0d busy cycles want 0", cyc); end
    checks++; if (LO !== 32'd5 || HI !== 32'd0) begin errors++; $display("FAIL madd_off_hilo: got %h want 5", {HI, LO}); end
`endif
  endtask

  task automatic test_random();
    int cyc, ecyc;
    logic [63:0] e;
    logic [3:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      drive_op(o, a, b, cyc, ecyc);
      e = exp_q.pop_front();
      checks++; if (cyc != ecyc) begin errors++; $display("FAIL rand_cycles[%0d] op=%0d: got %0d want %0d", i, o, cyc, ecyc); end
      checks++; if ({HI, LO} !== e) begin errors++; $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h: got %h want %h", i, o, a, b, {HI, LO}, e); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_by_zero();
    test_ignore_start();
    test_reset_midflight();
    test_back_to_back();
    test_madd();
    test_random();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
